state_machine: RTL and testbench
================================

# state_machine

Bit-serial full-adder controller. It adds two operands presented one bit per clock, LSB first, on A and B. The initial carry is CIN, sampled at the start of each word. The carry between bits is held as FSM state. Sum bit S and carry COUT are registered outputs, and the block sits between a bit-serial operand source and a serial result sink.

## Interface
- No parameters; all datapaths are 1 bit.
- CLK  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; forces IDLE, S=0, COUT=0 immediately.
- NRST  input  1  synchronous active-low clear; when 0 at a rising edge (rst=0), next state is IDLE and S=0, COUT=0.
- start  input  1  level enable; high = serial add in progress, low = idle/terminate word.
- A  input  1  operand A bit for the current cycle (LSB first).
- B  input  1  operand B bit for the current cycle (LSB first).
- CIN  input  1  carry-in for bit 0; sampled only on the IDLE→run transition.
- S  output  1  registered sum bit.
- COUT  output  1  registered carry out of the last added bit.

## Operation
- State register, 2 bits: IDLE=00, C0=01 (carry 0 held), C1=10 (carry 1 held). Encoding 11 is illegal and goes to IDLE with S=0, COUT=0 on the next edge.
- Let c be the incoming carry bit:
  - in IDLE, c=CIN;
  - in C0, c=0;
  - in C1, c=1.
- Priority at each rising edge, highest first: rst (async) > NRST=0 > start.
- With start=1 in any legal state:
  - S <= A^B^c;
  - COUT <= (A&B)|(A&c)|(B&c);
  - next state = C1 if the new carry is 1, else C0.
- With start=0 in C0/C1: next state IDLE. S <= 0, and COUT holds its value so the final word carry stays visible.
- With start=0 in IDLE: stay in IDLE, S <= 0, COUT holds.
- CIN is ignored in C0/C1. A new word needs start low for at least one cycle, which returns the FSM to IDLE so CIN is re-sampled.
- The word length is unbounded and set purely by how long start stays high. There is no internal counter and no wrap-around.

## Timing
- Reset values: S=0, COUT=0, state=IDLE. These apply asynchronously on rst=1 and hold while rst=1.
- Latency: one cycle. The A/B bit sampled at edge k appears on S/COUT after edge k and is valid for the whole following cycle.
- Throughput: one bit per clock while start=1, with no bubbles.
- rst asserted mid-word: the word is abandoned immediately. After rst deasserts, the next word starts only on an edge with start=1, and uses CIN.
- NRST=0 mid-word with start=1: the clear wins. S=0, COUT=0, IDLE. If start=1 and NRST=1 at the next edge, a new word begins and uses CIN.
- start and NRST=0 at the same edge: the clear wins.
- Inputs must be stable around the rising edge; no combinational path runs from inputs to outputs.

## Test plan
- Reset: rst=1 with arbitrary A, B, CIN, start -> S=0, COUT=0 immediately, independent of CLK. After release with start=0, outputs remain 0.
- 3+1 with CIN=0, start=1 for 3 cycles, A bits 1,1,0 and B bits 1,0,0 -> S sequence 0,0,1 with COUT sequence 1,1,0. The result is 4.
- CIN honoured: start rises with A=1, B=1, CIN=1 -> S=1, COUT=1. Next cycle A=0, B=0 with CIN toggled -> S=1, COUT=0, showing CIN is ignored mid-word.
- Word termination: after a word ending with COUT=1, drop start -> S=0 and COUT stays 1. The next word with CIN=0, A=0, B=0 gives S=0, COUT=0.
- Sync clear: mid-word in C1, drive NRST=0 with start=1 and A=B=1 -> S=0, COUT=0, state IDLE. The next edge with NRST=1, A=1, B=0, CIN=0 gives S=1, COUT=0.
- Random: 1000 random vectors {B,A,CIN,start,rst,NRST} applied one per clock. Compare against a bit-accurate reference model with the stated priority, every cycle.

Source files
------------

// File: rtl/state_machine_if.sv
// Bit-serial adder link: operand bits and word control in, registered sum/carry out.
interface state_machine_if;
  logic start;
  logic A;
  logic B;
  logic CIN;
  logic S;
  logic COUT;

  modport master (output start, output A, output B, output CIN, input S, input COUT);
  modport slave  (input start, input A, input B, input CIN, output S, output COUT);
endinterface

// File: rtl/state_machine.sv
// Bit-serial full adder: LSB-first operands, inter-bit carry held as FSM state.
module state_machine (
  input  logic            CLK,
  input  logic            rst,
  input  logic            NRST,
  state_machine_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] C0   = 2'b01;
  localparam logic [1:0] C1   = 2'b10;

  logic [1:0] state_q, state_d;
  logic       s_q, s_d;
  logic       cout_q, cout_d;
  logic       carryIn;
  logic       legal;

  always_comb begin
    carryIn = 1'b0;
    legal   = 1'b1;
    case (state_q)
      IDLE:    carryIn = bus.CIN;
      C0:      carryIn = 1'b0;
      C1:      carryIn = 1'b1;
      default: legal   = 1'b0;
    endcase
  end

  // Clear beats start; COUT is only dropped by a clear so the word's carry stays visible.
  always_comb begin
    state_d = IDLE;
    s_d     = 1'b0;
    cout_d  = cout_q;
    if (!NRST || !legal) begin
      cout_d = 1'b0;
    end else if (bus.start) begin
      s_d     = bus.A ^ bus.B ^ carryIn;
      cout_d  = (bus.A & bus.B) | (bus.A & carryIn) | (bus.B & carryIn);
      state_d = cout_d ? C1 : C0;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.S    = s_q;
  assign bus.COUT = cout_q;

endmodule

// File: tb/tb_state_machine.sv
// Directed and randomized checks of the bit-serial adder against hand-derived values.
module tb_state_machine;

  logic CLK;
  logic rst;
  logic NRST;
  int   testsRun;
  int   testsFailed;

  state_machine_if bus ();

  state_machine dut (
    .CLK  (CLK),
    .rst  (rst),
    .NRST (NRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, input logic a, input logic b, input logic cin);
    bus.start = st;
    bus.A     = a;
    bus.B     = b;
    bus.CIN   = cin;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    NRST = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_initial: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
    stepCycle();
    stepCycle();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b1 || bus.COUT !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_preword: S=%b COUT=%b, required S=1 COUT=1", bus.S, bus.COUT);
    end
    #2;
    rst = 1'b1;
    #1;
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_hold: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
  endtask

  task automatic test_add_3_1();
    logic [2:0] aBits = 3'b011;
    logic [2:0] bBits = 3'b001;
    logic [2:0] sExp  = 3'b100;
    logic [2:0] cExp  = 3'b011;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, aBits[i], bBits[i], 1'b0);
      stepCycle();
      testsRun++;
      if (bus.S !== sExp[i] || bus.COUT !== cExp[i]) begin
        testsFailed++;
        $display("[TB] FAIL add_3_1 bit%0d: S=%b COUT=%b, required S=%b COUT=%b",
                 i, bus.S, bus.COUT, sExp[i], cExp[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL add_3_1_end: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
  endtask

  task automatic test_cin();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b1 || bus.COUT !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL cin_first: S=%b COUT=%b, required S=1 COUT=1", bus.S, bus.COUT);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b1 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL cin_ignored: S=%b COUT=%b, required S=1 COUT=0", bus.S, bus.COUT);
    end
  endtask

  task automatic test_termination();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL term_word: S=%b COUT=%b, required S=0 COUT=1", bus.S, bus.COUT);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL term_hold: S=%b COUT=%b, required S=0 COUT=1", bus.S, bus.COUT);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL term_newword: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
  endtask

  task automatic test_sync_clear();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    stepCycle();
    NRST = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b0 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clear_wins: S=%b COUT=%b, required S=0 COUT=0", bus.S, bus.COUT);
    end
    NRST = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b1 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clear_restart: S=%b COUT=%b, required S=1 COUT=0", bus.S, bus.COUT);
    end
    NRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    NRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    stepCycle();
    testsRun++;
    if (bus.S !== 1'b1 || bus.COUT !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clear_cin: S=%b COUT=%b, required S=1 COUT=0", bus.S, bus.COUT);
    end
  endtask

  task automatic test_random();
    int         mState = 0;
    logic       mS     = 1'b0;
    logic       mCout  = 1'b0;
    logic       c;
    logic [1:0] sum;
    int         localFails = 0;
    rst  = 1'b1;
    NRST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    for (int i = 0; i < 1000; i++) begin
      rst       = ($urandom_range(0, 15) == 0);
      NRST      = ($urandom_range(0, 7) != 0);
      bus.start = ($urandom_range(0, 5) != 0);
      bus.A     = 1'($urandom_range(0, 1));
      bus.B     = 1'($urandom_range(0, 1));
      bus.CIN   = 1'($urandom_range(0, 1));
      if (rst || !NRST) begin
        mState = 0;
        mS     = 1'b0;
        mCout  = 1'b0;
      end else if (bus.start) begin
        c      = (mState == 0) ? bus.CIN : (mState == 2);
        sum    = 2'(bus.A) + 2'(bus.B) + 2'(c);
        mS     = sum[0];
        mCout  = sum[1];
        mState = sum[1] ? 2 : 1;
      end else begin
        mState = 0;
        mS     = 1'b0;
      end
      stepCycle();
      testsRun++;
      if (bus.S !== mS || bus.COUT !== mCout) begin
        testsFailed++;
        localFails++;
        if (localFails <= 10)
          $display("[TB] FAIL random cycle %0d: S=%b COUT=%b, required S=%b COUT=%b",
                   i, bus.S, bus.COUT, mS, mCout);
      end
    end
    rst = 1'b0;
    NRST = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_add_3_1();
    test_cin();
    test_termination();
    test_sync_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
